// File: rtl/uart_arb_pkg.sv
// Shared FSM encoding and timing defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // One bit time of idle between bytes keeps the serializer from back-to-back framing.
  localparam int CLKS_PER_BIT = 8;
  localparam int DEFAULT_GAP  = CLKS_PER_BIT;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first masked request after last_grant, modulo n_req.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  input  logic [N_REQ-1:0] mask,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  logic [N_REQ-1:0] masked;
  logic [ID_W-1:0]  idx;

  assign masked = req & mask;

  // Offsets 1..N_REQ visit every requester once, ending on last_grant itself.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!any_valid && masked[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX path among N_REQ byte sources.
// Define UART_ARB_LOCK_EN to add req_last and hold the grant across multi-byte messages.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = DEFAULT_GAP,
  parameter int ID_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arb_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t        state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic              grant_now;
  logic [GAP_W-1:0]  gap_cnt;
  logic [N_REQ-1:0]  lock_mask;
  logic [DATA_W-1:0] win_data;

`ifdef UART_ARB_LOCK_EN
  logic lock;
  logic win_last;

  always_comb begin
    lock_mask = '0;
    win_last  = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      lock_mask[i] = !lock || (last_grant == ID_W'(i));
      if (winner == ID_W'(i)) win_last = req_last[i];
    end
  end
`else
  assign lock_mask = '1;
`endif

  uart_rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .mask      (lock_mask),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Held off during reset so no requester hands over a byte that would be dropped.
  assign grant_now = !rst && arb_en && any_valid && (state == IDLE);

  always_comb begin
    req_ready = '0;
    win_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_now && (winner == ID_W'(i));
      if (winner == ID_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      gap_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            tx_data    <= win_data;
            grant_id   <= winner;
            last_grant <= winner;
            tx_valid   <= 1'b1;
            state      <= SEND;
`ifdef UART_ARB_LOCK_EN
            lock       <= !win_last;
`endif
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
